// File: rtl/mem_arbiter.sv
// Shares one single-port memory between instruction fetch (read) and data (read/write); ARB_ROUND_ROBIN_EN selects round-robin arbitration.
// state | meaning: IDLE sample requests | CMD one-cycle memory strobe | WAIT read latency | RESP owner ack
module mem_arbiter #(
    parameter int ADDR_W = 14,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              instReq,
    input  logic [ADDR_W-1:0] instAddr,
    output logic [DATA_W-1:0] instData,
    output logic              instAck,
    output logic              instStall,
    input  logic              dataRd,
    input  logic              dataWr,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWrData,
    output logic [DATA_W-1:0] dataRdData,
    output logic              dataAck,
    output logic              dataStall,
    output logic [ADDR_W-1:0] memAddr,
    output logic              memRd,
    output logic              memWr,
    output logic [DATA_W-1:0] memWrData,
    input  logic [DATA_W-1:0] memRdData
);

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CMD  = 2'd1,
        WAIT = 2'd2,
        RESP = 2'd3
    } state_t;

    state_t            state;
    state_t            state_nxt;

    logic              owner_data;
    logic              op_wr;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [CNT_W-1:0]  cnt;
    logic [DATA_W-1:0] inst_rdata;
    logic [DATA_W-1:0] data_rdata;

    logic              data_req;
    logic              grant_any;
    logic              grant_data;
    logic              grant;
    logic              capture;

    assign data_req  = dataRd | dataWr;
    assign grant_any = instReq | data_req;
    assign grant     = (state == IDLE) && grant_any;
    assign capture   = (state == WAIT) && (cnt == CNT_W'(1));

`ifdef ARB_ROUND_ROBIN_EN
    // last_data = 1 when the previous grant went to the data port
    logic last_data;

    assign grant_data = data_req & (~instReq | ~last_data);

    always_ff @(posedge clk) begin
        if (!rst) begin
            last_data <= 1'b0;
        end else if (grant) begin
            last_data <= grant_data;
        end
    end
`else
    assign grant_data = data_req;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (grant_any) begin
                    state_nxt = CMD;
                end
            end
            CMD: begin
                state_nxt = op_wr ? IDLE : WAIT;
            end
            WAIT: begin
                if (capture) begin
                    state_nxt = RESP;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // A simultaneous read and write from the data port collapses to the write
    always_ff @(posedge clk) begin
        if (!rst) begin
            owner_data <= 1'b0;
            op_wr      <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else if (grant) begin
            owner_data <= grant_data;
            op_wr      <= grant_data & dataWr;
            addr_q     <= grant_data ? dataAddr : instAddr;
            if (grant_data) begin
                wdata_q <= dataWrData;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if ((state == CMD) && !op_wr) begin
            cnt <= CNT_W'(RD_LAT);
        end else if ((state == WAIT) && (cnt != '0)) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            inst_rdata <= '0;
            data_rdata <= '0;
        end else if (capture) begin
            if (owner_data) begin
                data_rdata <= memRdData;
            end else begin
                inst_rdata <= memRdData;
            end
        end
    end

    always_comb begin
        memRd   = 1'b0;
        memWr   = 1'b0;
        instAck = 1'b0;
        dataAck = 1'b0;
        case (state)
            CMD: begin
                memRd   = ~op_wr;
                memWr   = op_wr;
                dataAck = op_wr;
            end
            RESP: begin
                instAck = ~owner_data;
                dataAck = owner_data;
            end
            default: begin
                memRd = 1'b0;
            end
        endcase
    end

    assign memAddr    = addr_q;
    assign memWrData  = wdata_q;
    assign instData   = inst_rdata;
    assign dataRdData = data_rdata;
    assign instStall  = instReq & ~instAck;
    assign dataStall  = data_req & ~dataAck;

endmodule
